// File: rtl/daccess_arbiter.sv
// daccess_arbiter: shares the CPU data-access bus between the MEM-stage
// requester (m0) and a secondary master (m1). One transaction in flight at
// a time; fixed-priority or round-robin arbitration; per-transaction timeout.
module daccess_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8,
  parameter bit RR_EN          = 1'b1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        m0_req,
  input  logic [3:0]  m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_wresp,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_wresp,
  output logic        m1_err,
  output logic [3:0]  daccess_ren,
  output logic [3:0]  daccess_wen,
  output logic [31:0] daccess_addr,
  output logic [31:0] daccess_wdata,
  input  logic        daccess_valid,
  input  logic [31:0] daccess_rdata,
  input  logic        daccess_wresp,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  // Counter value of the last cycle in which a response is still accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;   // 0 = m0, 1 = m1
  logic             last_q, last_d;     // master granted most recently
  logic             first_q, first_d;   // first cycle of RD/WR: bus strobe
  logic [3:0]       we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rvalid_q, rvalid_d; // per-master completion pulses
  logic [1:0]       wresp_q, wresp_d;
  logic [1:0]       err_q, err_d;

  logic idle, win, grant, hit, expire;
  logic [3:0] sel_we;

  // Arbitration and response qualification for the current cycle.
  always_comb begin
    idle = (state_q == ST_IDLE);
    if (m0_req && m1_req) win = RR_EN ? ~last_q : 1'b0;
    else                  win = m1_req;
    // Gated by reset so that a held request cannot grant while in reset.
    grant  = cpu_rstn && idle && (m0_req || m1_req);
    sel_we = win ? m1_we : m0_we;
    // Only the response matching the transaction type is honoured.
    hit    = ((state_q == ST_RD) && daccess_valid) ||
             ((state_q == ST_WR) && daccess_wresp);
    expire = !idle && !hit && (cnt_q == CNT_LAST);
  end

  // Next-state logic: latch request on grant, retire on response or timeout.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    first_d  = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    rvalid_d = 2'b00;
    wresp_d  = 2'b00;
    err_d    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d = win;
          last_d  = win;
          we_d    = sel_we;
          addr_d  = win ? m1_addr : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          first_d = 1'b1;
          cnt_d   = '0;
          state_d = (sel_we != 4'h0) ? ST_WR : ST_RD;
        end
      end
      ST_RD, ST_WR: begin
        if (hit) begin
          state_d = ST_IDLE;
          if (state_q == ST_RD) begin
            rvalid_d[owner_q] = 1'b1;
            rdata_d           = daccess_rdata;
          end else begin
            wresp_d[owner_q] = 1'b1;
          end
        end else if (expire) begin
          state_d         = ST_IDLE;
          err_d[owner_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset leaves the RR pointer on m1 so m0 wins the first tie.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      first_q  <= 1'b0;
      we_q     <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
      wresp_q  <= 2'b00;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      first_q  <= first_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      wresp_q  <= wresp_d;
      err_q    <= err_d;
    end
  end

  // Output decode; read data is presented only to the owner during its pulse.
  always_comb begin
    m0_gnt        = grant & ~win;
    m1_gnt        = grant & win;
    m0_rvalid     = rvalid_q[0];
    m1_rvalid     = rvalid_q[1];
    m0_rdata      = rvalid_q[0] ? rdata_q : 32'h0;
    m1_rdata      = rvalid_q[1] ? rdata_q : 32'h0;
    m0_wresp      = wresp_q[0];
    m1_wresp      = wresp_q[1];
    m0_err        = err_q[0];
    m1_err        = err_q[1];
    daccess_ren   = ((state_q == ST_RD) && first_q) ? 4'hF : 4'h0;
    daccess_wen   = ((state_q == ST_WR) && first_q) ? we_q : 4'h0;
    daccess_addr  = addr_q;
    daccess_wdata = wdata_q;
    busy          = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_daccess_arbiter.sv
// Bench for daccess_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level schedule model.
module tb_daccess_arbiter;
  localparam int TO = 4;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_wresp, m1_wresp, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  daccess_ren, daccess_wen;
  logic [31:0] daccess_addr, daccess_wdata, daccess_rdata;
  logic        daccess_valid, daccess_wresp, busy;

  int checks = 0;
  int errors = 0;

  daccess_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8), .RR_EN(1'b1)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_wresp(m0_wresp), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_wresp(m1_wresp), .m1_err(m1_err),
    .daccess_ren(daccess_ren), .daccess_wen(daccess_wen), .daccess_addr(daccess_addr),
    .daccess_wdata(daccess_wdata), .daccess_valid(daccess_valid), .daccess_rdata(daccess_rdata),
    .daccess_wresp(daccess_wresp), .busy(busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic clear_inputs;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    daccess_valid = 0; daccess_rdata = 0; daccess_wresp = 0;
  endtask

  task automatic do_reset;
    @(negedge cpu_clk); cpu_rstn = 0; clear_inputs();
    @(negedge cpu_clk); cpu_rstn = 1;
  endtask

  // Device answers a read in the cycle after the current one.
  task automatic serve_read(input logic [31:0] d);
    @(negedge cpu_clk); daccess_valid = 1; daccess_rdata = d;
    @(negedge cpu_clk); daccess_valid = 0;
  endtask

  task automatic test_reset;
    logic [199:0] outs;
    clear_inputs(); cpu_rstn = 0; m0_req = 1;
    repeat (2) @(negedge cpu_clk);
    #1;
    outs = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_wresp, m1_wresp, m0_err, m1_err,
            m0_rdata, m1_rdata, daccess_ren, daccess_wen, daccess_addr, daccess_wdata, busy};
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outs got %h exp 0", outs); end
    @(negedge cpu_clk); cpu_rstn = 1; m0_req = 0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_read;
    do_reset();
    @(negedge cpu_clk); m0_req = 1; m0_we = 0; m0_addr = 32'h0000_1000; #1;
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b exp 1", m0_gnt); end
    @(negedge cpu_clk); m0_req = 0; #1;
    checks++; if (daccess_ren !== 4'hF) begin errors++; $display("FAIL rd_ren_c1 got %h exp F", daccess_ren); end
    checks++; if (daccess_addr !== 32'h0000_1000) begin errors++; $display("FAIL rd_addr got %h exp 00001000", daccess_addr); end
    @(negedge cpu_clk); #1;
    checks++; if (daccess_ren !== 4'h0) begin errors++; $display("FAIL rd_ren_c2 got %h exp 0", daccess_ren); end
    @(negedge cpu_clk);
    @(negedge cpu_clk); daccess_valid = 1; daccess_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid got %b exp 0", m0_rvalid); end
    @(negedge cpu_clk); daccess_valid = 0; #1;
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL rd_data got %b/%h exp 1/deadbeef", m0_rvalid, m0_rdata); end
    checks++; if (busy !== 1'b0 || m0_err !== 1'b0) begin errors++; $display("FAIL rd_busy_err got %b%b exp 00", busy, m0_err); end
    @(negedge cpu_clk); #1;
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse_len got %b exp 0", m0_rvalid); end
    $display("test_read done");
  endtask

  task automatic test_round_robin;
    do_reset();
    @(negedge cpu_clk); m0_req = 1; m1_req = 1; m0_addr = 32'hA0; m1_addr = 32'hB0; #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rr_first got %b%b exp 10", m0_gnt, m1_gnt); end
    @(negedge cpu_clk); m0_req = 0; #1;
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL rr_busy_gnt got %b exp 0", m1_gnt); end
    serve_read(32'h1111_1111); #1;
    checks++; if (m0_rvalid !== 1'b1 || m1_gnt !== 1'b1 || m1_rvalid !== 1'b0)
      begin errors++; $display("FAIL rr_second got rv0=%b g1=%b rv1=%b exp 1 1 0", m0_rvalid, m1_gnt, m1_rvalid); end
    @(negedge cpu_clk); m1_req = 0; #1;
    checks++; if (daccess_addr !== 32'hB0) begin errors++; $display("FAIL rr_addr1 got %h exp b0", daccess_addr); end
    @(negedge cpu_clk); daccess_valid = 1; daccess_rdata = 32'h2222_2222;
    @(negedge cpu_clk); daccess_valid = 0; m0_req = 1; m1_req = 1; #1;
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h2222_2222 || m0_rvalid !== 1'b0 || m0_rdata !== 32'h0)
      begin errors++; $display("FAIL rr_m1data got %b/%h m0 %b/%h", m1_rvalid, m1_rdata, m0_rvalid, m0_rdata); end
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rr_third got %b%b exp 10", m0_gnt, m1_gnt); end
    @(negedge cpu_clk); m0_req = 0;
    serve_read(32'h3); #1;
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL rr_fourth got %b exp 1", m1_gnt); end
    @(negedge cpu_clk); m1_req = 0;
    serve_read(32'h4); #1;
    checks++; if (m1_rvalid !== 1'b1) begin errors++; $display("FAIL rr_last_rv got %b exp 1", m1_rvalid); end
    $display("test_round_robin done");
  endtask

  task automatic test_write;
    do_reset();
    @(negedge cpu_clk); m1_req = 1; m1_we = 4'b0011; m1_addr = 32'h0000_2002; m1_wdata = 32'h0000_ABCD; #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL wr_gnt got %b%b exp 01", m0_gnt, m1_gnt); end
    @(negedge cpu_clk); m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; #1;
    checks++; if (daccess_wen !== 4'b0011 || daccess_ren !== 4'h0)
      begin errors++; $display("FAIL wr_wen got %b ren %h exp 0011 0", daccess_wen, daccess_ren); end
    checks++; if (daccess_addr !== 32'h2002 || daccess_wdata !== 32'hABCD)
      begin errors++; $display("FAIL wr_latch got %h/%h exp 2002/abcd", daccess_addr, daccess_wdata); end
    @(negedge cpu_clk); daccess_valid = 1; #1;
    checks++; if (daccess_wen !== 4'h0 || daccess_wdata !== 32'hABCD)
      begin errors++; $display("FAIL wr_hold got %b/%h exp 0000/abcd", daccess_wen, daccess_wdata); end
    @(negedge cpu_clk); daccess_valid = 0; daccess_wresp = 1; #1;
    checks++; if (m1_rvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_valid_ignored got rv %b busy %b", m1_rvalid, busy); end
    @(negedge cpu_clk); daccess_wresp = 0; #1;
    checks++; if (m1_wresp !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wr_resp got %b busy %b exp 1 0", m1_wresp, busy); end
    checks++; if ({m0_gnt, m0_rvalid, m0_wresp, m0_err, m0_rdata} !== '0)
      begin errors++; $display("FAIL wr_m0_quiet got %b%b%b%b %h", m0_gnt, m0_rvalid, m0_wresp, m0_err, m0_rdata); end
    $display("test_write done");
  endtask

  task automatic test_timeout;
    do_reset();
    @(negedge cpu_clk); m0_req = 1; #1;
    @(negedge cpu_clk); m0_req = 0; daccess_wresp = 1;
    @(negedge cpu_clk); daccess_wresp = 0;
    @(negedge cpu_clk);
    @(negedge cpu_clk); #1;
    checks++; if (m0_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_c4 got err %b busy %b exp 0 1", m0_err, busy); end
    @(negedge cpu_clk); #1;
    checks++; if (m0_err !== 1'b1 || busy !== 1'b0 || m0_rvalid !== 1'b0)
      begin errors++; $display("FAIL to_c5 got err %b busy %b rv %b exp 1 0 0", m0_err, busy, m0_rvalid); end
    @(negedge cpu_clk); daccess_valid = 1; #1;
    checks++; if (m0_err !== 1'b0) begin errors++; $display("FAIL to_err_len got %b exp 0", m0_err); end
    @(negedge cpu_clk); daccess_valid = 0; #1;
    checks++; if (m0_rvalid !== 1'b0 || m0_err !== 1'b0) begin errors++; $display("FAIL to_stale got rv %b err %b exp 0 0", m0_rvalid, m0_err); end
    $display("test_timeout done");
  endtask

  task automatic test_async_reset;
    do_reset();
    @(negedge cpu_clk); m0_req = 1; m0_addr = 32'h55; #1;
    @(negedge cpu_clk); m0_req = 0;
    @(negedge cpu_clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_busy_pre got %b exp 1", busy); end
    cpu_rstn = 0; #1;
    checks++; if (busy !== 1'b0 || daccess_addr !== 32'h0) begin errors++; $display("FAIL ar_now got busy %b addr %h exp 0 0", busy, daccess_addr); end
    @(negedge cpu_clk); cpu_rstn = 1;
    @(negedge cpu_clk); daccess_valid = 1; daccess_rdata = 32'h77;
    @(negedge cpu_clk); daccess_valid = 0; #1;
    checks++; if (m0_rvalid !== 1'b0 || m0_err !== 1'b0) begin errors++; $display("FAIL ar_dropped got rv %b err %b exp 0 0", m0_rvalid, m0_err); end
    @(negedge cpu_clk); m0_req = 1; #1;
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL ar_regrant got %b exp 1", m0_gnt); end
    @(negedge cpu_clk); m0_req = 0;
    serve_read(32'h88); #1;
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h88) begin errors++; $display("FAIL ar_read got %b/%h exp 1/88", m0_rvalid, m0_rdata); end
    $display("test_async_reset done");
  endtask

  // Randomized traffic: the model schedules, per grant, the bus-request
  // cycle, the response cycle (or timeout) and the resulting owner pulse.
  task automatic test_random(input int ncyc);
    bit          pend[2];
    logic [3:0]  pwe[2];
    logic [31:0] pa[2], pw[2];
    bit          mb = 0, mwr = 0;
    int          own = 0, c1 = 0, resp_c = -1, end_c = 0, tkind = 0;
    int          pcyc = -1, pkind = 0, pown = 0, last = 1, win, off;
    logic [3:0]  mwe = 0;
    logic [31:0] ma = 0, mw = 0, prd = 0;
    bit          g[2], rv[2], wr[2], er[2];
    logic [3:0]  e_ren, e_wen;
    do_reset();
    pend[0] = 0; pend[1] = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge cpu_clk);
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(2) == 0) begin
          pend[m] = 1;
          pwe[m]  = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
          pa[m]   = $urandom; pw[m] = $urandom;
        end
      m0_req = pend[0]; m0_we = pwe[0]; m0_addr = pa[0]; m0_wdata = pw[0];
      m1_req = pend[1]; m1_we = pwe[1]; m1_addr = pa[1]; m1_wdata = pw[1];
      daccess_rdata = $urandom;
      daccess_valid = ($urandom_range(3) == 0);
      daccess_wresp = ($urandom_range(3) == 0);
      if (mb && !mwr) daccess_valid = (cyc == resp_c);
      if (mb && mwr)  daccess_wresp = (cyc == resp_c);
      if (mb && !mwr && cyc == resp_c) prd = daccess_rdata;
      win = -1;
      if (!mb && (pend[0] || pend[1]))
        win = (pend[0] && pend[1]) ? (last == 0 ? 1 : 0) : (pend[1] ? 1 : 0);
      for (int m = 0; m < 2; m++) begin
        g[m]  = (win == m);
        rv[m] = (cyc == pcyc) && (pown == m) && (pkind == 0);
        wr[m] = (cyc == pcyc) && (pown == m) && (pkind == 1);
        er[m] = (cyc == pcyc) && (pown == m) && (pkind == 2);
      end
      e_ren = (mb && cyc == c1 && !mwr) ? 4'hF : 4'h0;
      e_wen = (mb && cyc == c1 && mwr) ? mwe : 4'h0;
      #1;
      checks++; if ({m0_gnt, m1_gnt} !== {g[0], g[1]})
        begin errors++; $display("FAIL rnd_gnt cyc %0d got %b%b exp %b%b", cyc, m0_gnt, m1_gnt, g[0], g[1]); end
      checks++; if (busy !== mb) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", cyc, busy, mb); end
      checks++; if (daccess_ren !== e_ren || daccess_wen !== e_wen)
        begin errors++; $display("FAIL rnd_strobe cyc %0d got %h/%h exp %h/%h", cyc, daccess_ren, daccess_wen, e_ren, e_wen); end
      if (mb) begin
        checks++; if (daccess_addr !== ma || daccess_wdata !== mw)
          begin errors++; $display("FAIL rnd_latch cyc %0d got %h/%h exp %h/%h", cyc, daccess_addr, daccess_wdata, ma, mw); end
      end
      checks++; if ({m0_rvalid, m1_rvalid, m0_wresp, m1_wresp, m0_err, m1_err} !== {rv[0], rv[1], wr[0], wr[1], er[0], er[1]})
        begin errors++; $display("FAIL rnd_pulses cyc %0d got %b%b%b%b%b%b exp %b%b%b%b%b%b", cyc,
          m0_rvalid, m1_rvalid, m0_wresp, m1_wresp, m0_err, m1_err, rv[0], rv[1], wr[0], wr[1], er[0], er[1]); end
      if (rv[0]) begin
        checks++; if (m0_rdata !== prd || m1_rdata !== 32'h0)
          begin errors++; $display("FAIL rnd_rdata0 cyc %0d got %h/%h exp %h/0", cyc, m0_rdata, m1_rdata, prd); end
      end
      if (rv[1]) begin
        checks++; if (m1_rdata !== prd || m0_rdata !== 32'h0)
          begin errors++; $display("FAIL rnd_rdata1 cyc %0d got %h/%h exp %h/0", cyc, m1_rdata, m0_rdata, prd); end
      end
      if (mb && cyc == end_c) begin
        mb = 0; pcyc = cyc + 1; pown = own; pkind = tkind;
        $display("txn m%0d kind %0d ends cyc %0d", own, tkind, cyc);
      end
      if (win >= 0) begin
        mb = 1; own = win; last = win; pend[win] = 0;
        mwe = pwe[win]; ma = pa[win]; mw = pw[win]; mwr = (mwe != 4'h0);
        c1 = cyc + 1;
        off = $urandom_range(TO + 1, 0);
        if (off <= TO - 1) begin resp_c = c1 + off; end_c = resp_c; tkind = mwr ? 1 : 0; end
        else begin resp_c = -1; end_c = c1 + TO - 1; tkind = 2; end
      end
    end
    clear_inputs();
    $display("test_random done");
  endtask

  initial begin
    clear_inputs();
    cpu_rstn = 0;
    test_reset();
    test_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_async_reset();
    test_random(600);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
